ddr_wr_queue: RTL and testbench
===============================

Name: ddr_wr_queue

Overview:
Write-side queue feeding the DDR write dispatcher. It packs the 32-bit capture samples from the logic-analyzer front end into 128-bit lines and generates a linear, wrapping DDR address per line. Data and address go into two parallel show-ahead FIFOs. The dispatcher drains them independently using has_wr_data/get_wr_data and has_wr_adx/get_wr_adx.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth in lines (both FIFOs have the same depth, 16 entries by default)
BASE_ADDR, 27'h0000000, first line address; must be a multiple of 8
END_ADDR, 27'h7FFFFF8, last line address before wrap; must be a multiple of 8 and ≥ BASE_ADDR

Ports:
clk  in  1  system clock; all logic is on the rising edge
reset  in  1  synchronous reset, active-high
sample_in  in  32  capture sample
sample_valid  in  1  sample_in is valid this cycle
sample_ready  out  1  queue accepts a sample this cycle
flush  in  1  single-cycle pulse: push the partial line, zero-padded
get_wr_data  in  1  pop the data FIFO
get_wr_adx  in  1  pop the address FIFO
has_wr_data  out  1  data FIFO is not empty
has_wr_adx  out  1  address FIFO is not empty
wr_data  out  128  data FIFO head (show-ahead)
wr_adx  out  27  address FIFO head (show-ahead)
fill_level  out  DEPTH_LOG2+1  data FIFO occupancy
overflow  out  1  sticky: a sample was offered while sample_ready was low
wrapped  out  1  one-cycle pulse when the address counter wraps
hwm  out  DEPTH_LOG2+1  high-water mark of fill_level (see Optional Feature)

Behaviour:
- Reset values: lane=0; line buffer=0; addr_ctr=BASE_ADDR; both FIFOs empty (has_*=0, fill_level=0); overflow=0; wrapped=0; hwm=0; flush_pend=0; sample_ready=1. wr_data and wr_adx show don't-care memory content while empty. Reset mid-operation discards all queued lines and any partial line.
- Packing:
  - A sample is accepted when sample_valid & sample_ready.
  - The sample is written to line bits [32*lane+31 : 32*lane]. Lane 0 is the lowest 32 bits.
  - lane increments 0→3 and then returns to 0.
- Line push:
  - Occurs on accepting the lane-3 sample, or when a flush is serviced.
  - The cycle after the accepting edge, the full 128-bit line (with the new sample) is in the data FIFO and addr_ctr is in the address FIFO. Both FIFOs are written in the same cycle.
  - After each push: addr_ctr ← addr_ctr+8. If addr_ctr == END_ADDR, addr_ctr ← BASE_ADDR instead and wrapped pulses for 1 cycle.
- full = (data count == 2^DEPTH_LOG2) OR (address count == 2^DEPTH_LOG2), computed from the registered counts.
- sample_ready = ~(lane==3 & full) & ~flush_pend. A pop in the same cycle does NOT make room (there is no pass-through).
- Overflow: sample_valid & ~sample_ready sets overflow. The sample is dropped. Only reset clears overflow.
- Flush handling:
  - flush with lane==0 and not flush_pend: no-op.
  - flush with lane>0: set flush_pend.
  - When flush_pend & ~full: push the line with lanes ≥ lane forced to 0, then lane←0 and flush_pend←0.
  - flush arriving while flush_pend=1 is ignored.
  - flush in the same cycle as an accepted sample: the sample is packed first, and the flush applies to the resulting lane. If that sample completes the line, the normal push happens and the flush is a no-op.
- FIFOs:
  - Independent read pointers.
  - A pop while empty is ignored; the pointer and count are unchanged.
  - Simultaneous push and pop on a non-full FIFO: count unchanged and both pointers advance.
  - Pointers wrap modulo 2^DEPTH_LOG2.
  - has_wr_* = count != 0.
  - The head updates the cycle after a pop, or the cycle after a push into an empty FIFO.

Optional Feature:
- Macro WR_QUEUE_HWM_EN.
- When defined: hwm is a register that updates to fill_level whenever fill_level > hwm. Only reset clears it.
- When undefined: hwm is tied to 0 and no register is built.

Test Plan:
- Push 4 samples 0x11111111, 0x22222222, 0x33333333, 0x44444444 back-to-back → 1 cycle later has_wr_data=has_wr_adx=1, wr_data=128'h44444444_33333333_22222222_11111111, wr_adx=0, fill_level=1.
- Stream 17 lines with no pops (DEPTH_LOG2=4) → fill_level=16 and sample_ready=0 at lane 3 of line 17. A held valid sets overflow=1. Subsequent pops restore sample_ready=1, and overflow stays 1.
- BASE_ADDR=0x100, END_ADDR=0x110, push 4 lines → addresses 0x100, 0x108, 0x110, 0x100. wrapped pulses once, the cycle after the 3rd push.
- Push 2 samples 0xA, 0xB then flush → one line 128'h0_0_B_A is pushed, and the next line starts at lane 0. A flush with lane=0 pushes nothing.
- Pop the address FIFO 3× while the data FIFO is untouched (3 lines queued) → has_wr_adx=0, has_wr_data=1, fill_level=3. A 4th get_wr_adx is ignored with no underflow.
- With WR_QUEUE_HWM_EN: fill to 5, drain to 0 → hwm=5. Without the macro → hwm=0 throughout.

Source files
------------

// File: rtl/ddr_wr_queue.sv
`default_nettype none
// ============================================================================
//  Module   : ddr_wr_queue
//  Purpose  : Write-side queue for the DDR write dispatcher. Packs 32-bit
//             capture samples into 128-bit lines and assigns each line a
//             linear, wrapping DDR line address. Lines and addresses are
//             held in two parallel show-ahead FIFOs that are drained
//             independently.
//  Ports    : clk, reset          - clock, synchronous active-high reset
//             sample_in/valid/ready - sample input handshake
//             flush               - push the partial line, zero-padded
//             get_wr_data/adx     - pop the data / address FIFO
//             has_wr_data/adx     - FIFO not empty
//             wr_data, wr_adx     - FIFO heads (show-ahead)
//             fill_level          - data FIFO occupancy
//             overflow            - sticky: sample offered while not ready
//             wrapped             - one-cycle pulse on address wrap
//             hwm                 - high-water mark of fill_level
//  Options  : WR_QUEUE_HWM_EN     - build the high-water-mark register;
//                                   otherwise hwm is tied to zero
//  Revision : 1.0 - initial release
// ============================================================================
module ddr_wr_queue #(
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [26:0] BASE_ADDR  = 27'h0000000,
  parameter logic [26:0] END_ADDR   = 27'h7FFFFF8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           sample_in,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  input  logic                  flush,
  input  logic                  get_wr_data,
  input  logic                  get_wr_adx,
  output logic                  has_wr_data,
  output logic                  has_wr_adx,
  output logic [127:0]          wr_data,
  output logic [26:0]           wr_adx,
  output logic [DEPTH_LOG2:0]   fill_level,
  output logic                  overflow,
  output logic                  wrapped,
  output logic [DEPTH_LOG2:0]   hwm
);

  localparam int                    c_depth    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   c_cnt_full = (DEPTH_LOG2 + 1)'(c_depth);
  localparam logic [DEPTH_LOG2:0]   c_cnt_one  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] c_ptr_one  = DEPTH_LOG2'(1);

  // Packing state
  logic [1:0]            r_lane;
  logic [127:0]          r_line;
  logic [26:0]           r_addr_ctr;
  logic                  r_flush_pend;
  logic                  r_overflow;
  logic                  r_wrapped;

  // FIFO storage; both FIFOs are always written together so they share
  // one write pointer, while reads and counts are independent.
  logic [127:0]          r_data_mem [c_depth];
  logic [26:0]           r_adx_mem  [c_depth];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr_data;
  logic [DEPTH_LOG2-1:0] r_rd_ptr_adx;
  logic [DEPTH_LOG2:0]   r_cnt_data;
  logic [DEPTH_LOG2:0]   r_cnt_adx;

  logic                  w_full;
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_service_flush;
  logic                  w_push;
  logic                  w_pop_data;
  logic                  w_pop_adx;
  logic [127:0]          w_packed;
  logic [127:0]          w_flush_line;
  logic [127:0]          w_push_data;

  assign w_full  = (r_cnt_data == c_cnt_full) || (r_cnt_adx == c_cnt_full);
  // Only the lane-3 sample needs FIFO room; earlier lanes just fill the
  // line buffer. A pending flush blocks samples until its line is pushed.
  assign w_ready  = ~((r_lane == 2'd3) & w_full) & ~r_flush_pend;
  assign w_accept = sample_valid & w_ready;

  assign w_service_flush = r_flush_pend & ~w_full;
  assign w_push          = (w_accept & (r_lane == 2'd3)) | w_service_flush;
  assign w_push_data     = w_service_flush ? w_flush_line : w_packed;

  assign w_pop_data = get_wr_data & (r_cnt_data != '0);
  assign w_pop_adx  = get_wr_adx  & (r_cnt_adx  != '0);

  // Line buffer with the incoming sample merged into its lane
  always_comb begin
    w_packed = r_line;
    w_packed[{r_lane, 5'd0} +: 32] = sample_in;
  end

  // Partial line for a flush: lanes not yet written this line read as zero,
  // since the buffer still holds stale samples from the previous line.
  always_comb begin
    w_flush_line = r_line;
    for (int i = 0; i < 4; i++) begin
      if (2'(i) >= r_lane) begin
        w_flush_line[32*i +: 32] = 32'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lane        <= 2'd0;
      r_line        <= '0;
      r_addr_ctr    <= BASE_ADDR;
      r_flush_pend  <= 1'b0;
      r_overflow    <= 1'b0;
      r_wrapped     <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr_data <= '0;
      r_rd_ptr_adx  <= '0;
      r_cnt_data    <= '0;
      r_cnt_adx     <= '0;
    end else begin
      r_wrapped <= 1'b0;

      if (sample_valid & ~w_ready) begin
        r_overflow <= 1'b1;
      end

      if (w_service_flush) begin
        r_lane       <= 2'd0;
        r_flush_pend <= 1'b0;
      end else if (w_accept) begin
        r_line <= w_packed;
        r_lane <= r_lane + 2'd1;
        // A flush alongside a line-completing sample has nothing left to
        // push; otherwise it applies to the advanced (non-zero) lane.
        if (flush && (r_lane != 2'd3)) begin
          r_flush_pend <= 1'b1;
        end
      end else if (flush && (r_lane != 2'd0)) begin
        r_flush_pend <= 1'b1;
      end

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
        if (r_addr_ctr == END_ADDR) begin
          r_addr_ctr <= BASE_ADDR;
          r_wrapped  <= 1'b1;
        end else begin
          r_addr_ctr <= r_addr_ctr + 27'd8;
        end
      end

      if (w_pop_data) begin
        r_rd_ptr_data <= r_rd_ptr_data + c_ptr_one;
      end
      if (w_pop_adx) begin
        r_rd_ptr_adx <= r_rd_ptr_adx + c_ptr_one;
      end

      // A push never happens when full, so push+pop leaves count unchanged
      case ({w_push, w_pop_data})
        2'b10:   r_cnt_data <= r_cnt_data + c_cnt_one;
        2'b01:   r_cnt_data <= r_cnt_data - c_cnt_one;
        default: r_cnt_data <= r_cnt_data;
      endcase
      case ({w_push, w_pop_adx})
        2'b10:   r_cnt_adx <= r_cnt_adx + c_cnt_one;
        2'b01:   r_cnt_adx <= r_cnt_adx - c_cnt_one;
        default: r_cnt_adx <= r_cnt_adx;
      endcase
    end
  end

  // FIFO memories carry no reset; their content is don't-care while empty
  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_data_mem[r_wr_ptr] <= w_push_data;
      r_adx_mem[r_wr_ptr]  <= r_addr_ctr;
    end
  end

  assign sample_ready = w_ready;
  assign has_wr_data  = (r_cnt_data != '0);
  assign has_wr_adx   = (r_cnt_adx != '0);
  assign wr_data      = r_data_mem[r_rd_ptr_data];
  assign wr_adx       = r_adx_mem[r_rd_ptr_adx];
  assign fill_level   = r_cnt_data;
  assign overflow     = r_overflow;
  assign wrapped      = r_wrapped;

`ifdef WR_QUEUE_HWM_EN
  logic [DEPTH_LOG2:0] r_hwm;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hwm <= '0;
    end else if (r_cnt_data > r_hwm) begin
      r_hwm <= r_cnt_data;
    end
  end

  assign hwm = r_hwm;
`else
  assign hwm = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ddr_wr_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ddr_wr_queue
//  Purpose  : Self-checking bench for ddr_wr_queue. Directed scenarios
//             followed by randomized traffic, all compared cycle by cycle
//             against a queue-based reference model. Honours
//             WR_QUEUE_HWM_EN in the same way as the design.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ddr_wr_queue;

  localparam int          DL   = 4;
  localparam int          DEP  = 1 << DL;
  localparam logic [26:0] BASE = 27'h100;
  localparam logic [26:0] ENDA = 27'h110;

  logic          clk;
  logic          reset;
  logic [31:0]   sample_in;
  logic          sample_valid;
  logic          sample_ready;
  logic          flush;
  logic          get_wr_data;
  logic          get_wr_adx;
  logic          has_wr_data;
  logic          has_wr_adx;
  logic [127:0]  wr_data;
  logic [26:0]   wr_adx;
  logic [DL:0]   fill_level;
  logic          overflow;
  logic          wrapped;
  logic [DL:0]   hwm;

  ddr_wr_queue #(
    .DEPTH_LOG2 (DL),
    .BASE_ADDR  (BASE),
    .END_ADDR   (ENDA)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .flush        (flush),
    .get_wr_data  (get_wr_data),
    .get_wr_adx   (get_wr_adx),
    .has_wr_data  (has_wr_data),
    .has_wr_adx   (has_wr_adx),
    .wr_data      (wr_data),
    .wr_adx       (wr_adx),
    .fill_level   (fill_level),
    .overflow     (overflow),
    .wrapped      (wrapped),
    .hwm          (hwm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queued lines/addresses plus the samples of the line
  // currently being assembled.
  logic [127:0] m_dq[$];
  logic [26:0]  m_aq[$];
  logic [31:0]  m_part[$];
  logic [26:0]  m_addr;
  bit           m_pend;
  bit           m_ovf;
  bit           m_wrap;
  int           m_hwm;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pack_part();
    logic [127:0] l;
    l = '0;
    for (int i = 0; i < m_part.size(); i++) l[32*i +: 32] = m_part[i];
    return l;
  endfunction

  function automatic bit m_full();
    return (m_dq.size() == DEP) || (m_aq.size() == DEP);
  endfunction

  function automatic bit m_ready();
    return !((m_part.size() == 3) && m_full()) && !m_pend;
  endfunction

  task automatic m_push_line(input logic [127:0] l);
    m_dq.push_back(l);
    m_aq.push_back(m_addr);
    if (m_addr == ENDA) begin
      m_addr = BASE;
      m_wrap = 1'b1;
    end else begin
      m_addr = m_addr + 27'd8;
    end
  endtask

  task automatic check_outputs();
    chk("has_wr_data", has_wr_data, m_dq.size() != 0);
    chk("has_wr_adx", has_wr_adx, m_aq.size() != 0);
    chk("fill_level", fill_level, m_dq.size());
    chk("overflow", overflow, m_ovf);
    chk("wrapped", wrapped, m_wrap);
    chk("hwm", hwm, m_hwm);
    if (m_dq.size() != 0) chk("wr_data", wr_data, m_dq[0]);
    if (m_aq.size() != 0) chk("wr_adx", wr_adx, m_aq[0]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sample_valid = 1'b0;
    sample_in = '0;
    flush = 1'b0;
    get_wr_data = 1'b0;
    get_wr_adx = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_dq.delete();
    m_aq.delete();
    m_part.delete();
    m_addr = BASE;
    m_pend = 1'b0;
    m_ovf = 1'b0;
    m_wrap = 1'b0;
    m_hwm = 0;
    check_outputs();
    chk("reset_ready", sample_ready, 1'b1);
  endtask

  // One clock: drive inputs, check ready, advance model across the edge
  task automatic cycle(input bit v, input logic [31:0] s, input bit f, input bit gd, input bit ga);
    bit rdy, full, acc, popd, popa;
    sample_valid = v;
    sample_in = s;
    flush = f;
    get_wr_data = gd;
    get_wr_adx = ga;
    #1;
    rdy  = m_ready();
    full = m_full();
    acc  = v && rdy;
    popd = gd && (m_dq.size() != 0);
    popa = ga && (m_aq.size() != 0);
    chk("sample_ready", sample_ready, rdy);
`ifdef WR_QUEUE_HWM_EN
    if (m_dq.size() > m_hwm) m_hwm = m_dq.size();
`endif
    @(posedge clk);
    #1;
    m_wrap = 1'b0;
    if (v && !rdy) m_ovf = 1'b1;
    if (popd) void'(m_dq.pop_front());
    if (popa) void'(m_aq.pop_front());
    if (m_pend) begin
      if (!full) begin
        m_push_line(pack_part());
        m_part.delete();
        m_pend = 1'b0;
      end
    end else if (acc) begin
      m_part.push_back(s);
      if (m_part.size() == 4) begin
        m_push_line(pack_part());
        m_part.delete();
      end else if (f) begin
        m_pend = 1'b1;
      end
    end else if (f && (m_part.size() != 0)) begin
      m_pend = 1'b1;
    end
    check_outputs();
  endtask

  logic [26:0] exp_adx [4];

  initial begin
    exp_adx[0] = 27'h100;
    exp_adx[1] = 27'h108;
    exp_adx[2] = 27'h110;
    exp_adx[3] = 27'h100;

    do_reset();

    // Flush at lane 0 is a no-op; then a two-sample partial line
    cycle(0, 0, 1, 0, 0);
    cycle(1, 32'hA, 0, 0, 0);
    cycle(1, 32'hB, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("flush_line", wr_data, 128'h00000000_00000000_0000000B_0000000A);
    chk("flush_fill", fill_level, 1);
    cycle(0, 0, 0, 1, 1);

    // Four back-to-back samples form one full line
    cycle(1, 32'h11111111, 0, 0, 0);
    cycle(1, 32'h22222222, 0, 0, 0);
    cycle(1, 32'h33333333, 0, 0, 0);
    cycle(1, 32'h44444444, 0, 0, 0);
    chk("line4", wr_data, 128'h44444444_33333333_22222222_11111111);
    chk("line4_adx", wr_adx, 27'h108);
    cycle(0, 0, 0, 1, 1);

    // Flush together with an accepted sample, and with a line-completing one
    cycle(1, 32'h5, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) cycle(1, 32'(i), (i == 4), 0, 0);
    cycle(0, 0, 1, 0, 0);
    repeat (4) cycle(0, 0, 0, 1, 1);

    // Address sequence and wrap from a clean start
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1, $urandom, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("wrap_adx", wr_adx, exp_adx[i]);
      cycle(0, 0, 0, 1, 1);
    end

    // Fill to capacity, hold valid to provoke overflow, then drain a little
    do_reset();
    for (int i = 0; i < 68; i++) cycle(1, $urandom, 0, 0, 0);
    chk("full_ready", sample_ready, 1'b0);
    chk("full_fill", fill_level, DEP);
    chk("full_ovf", overflow, 1'b1);
    cycle(1, $urandom, 0, 1, 1);
    repeat (3) cycle(0, 0, 0, 1, 1);
    chk("drain_ready", sample_ready, 1'b1);
    chk("drain_ovf", overflow, 1'b1);

    // Reset with lines still queued, then address-only pops
    do_reset();
    for (int i = 0; i < 12; i++) cycle(1, $urandom, 0, 0, 0);
    repeat (4) cycle(0, 0, 0, 0, 1);
    chk("adxpop_has_adx", has_wr_adx, 1'b0);
    chk("adxpop_has_data", has_wr_data, 1'b1);
    chk("adxpop_fill", fill_level, 3);

    // High-water mark: fill to five lines and drain fully
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1, $urandom, 0, 0, 0);
    repeat (7) cycle(0, 0, 0, 1, 1);
`ifdef WR_QUEUE_HWM_EN
    chk("hwm_final", hwm, 5);
`else
    chk("hwm_final", hwm, 0);
`endif

    // Random traffic: a slow-drain phase that reaches full, then fast drain
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 11) == 0,
            $urandom_range(0, (i < 1500) ? 4 : 1) == 0,
            $urandom_range(0, (i < 1500) ? 4 : 1) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
